// File: rtl/latch_strobe_pkg.sv
// Shared types and constants for the latch strobe transmitter:
// FSM state encoding, parameter defaults and phase counter width.
package latch_strobe_pkg;

   localparam int DATA_W_DEF    = 8;
   localparam int SETUP_CYC_DEF = 1;
   localparam int PULSE_CYC_DEF = 2;
   localparam int HOLD_CYC_DEF  = 1;
   localparam int CNT_W         = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

endpackage

// File: rtl/lst_phase_counter.sv
// Loadable phase down-counter; saturates at zero and flags it so the
// FSM can advance without the count ever wrapping.
module lst_phase_counter
   import latch_strobe_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/latch_strobe_tx.sv
// Drives a word and a flop-generated enable strobe into a downstream
// transparent latch with programmable setup/pulse/hold. Optional lat_par
// output is enabled by defining LATCH_STROBE_PARITY_EN.
module latch_strobe_tx
   import latch_strobe_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SETUP_CYC = SETUP_CYC_DEF,
   parameter int PULSE_CYC = PULSE_CYC_DEF,
   parameter int HOLD_CYC  = HOLD_CYC_DEF
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] lat_d,
   output logic              lat_en,
`ifdef LATCH_STROBE_PARITY_EN
   output logic              lat_par,
`endif
   output logic              busy,
   output logic              done
);

   // Each phase lasts N cycles, so the counter is loaded with N-1 on entry.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
   localparam bit               HAS_HOLD = (HOLD_CYC != 0);

   state_t           state;
   state_t           state_next;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_zero;
   logic             accept;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   lst_phase_counter u_phase_counter (
      .clk      (clk),
      .rstn     (rstn),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next   = SETUP;
               cnt_load     = 1'b1;
               cnt_load_val = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt_zero) begin
               state_next   = STROBE;
               cnt_load     = 1'b1;
               cnt_load_val = PULSE_LD;
            end
         end
         STROBE: begin
            if (cnt_zero) begin
               if (HAS_HOLD) begin
                  state_next   = HOLD;
                  cnt_load     = 1'b1;
                  cnt_load_val = HOLD_LD;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // lat_en and done come from flops fed by the next state, keeping the strobe glitch-free.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lat_d  <= '0;
         lat_en <= 1'b0;
         done   <= 1'b0;
      end else begin
         if (accept) begin
            lat_d <= in_data;
         end
         lat_en <= (state_next == STROBE);
         done   <= (state != IDLE) && (state_next == IDLE);
      end
   end

`ifdef LATCH_STROBE_PARITY_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lat_par <= 1'b0;
      end else if (accept) begin
         lat_par <= ^in_data;
      end
   end
`endif

endmodule

// File: tb/tb_latch_strobe_tx.sv
// Scoreboard bench for latch_strobe_tx: directed words push expected strobe
// and done timing; a negedge monitor pops and compares as events appear.
module tb_latch_strobe_tx;

   logic       clk = 1'b0;
   logic       rstn;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [7:0] lat_d;
   logic       lat_en;
   logic       busy;
   logic       done;

   logic       in_valid_b;
   logic [7:0] in_data_b;
   logic       in_ready_b;
   logic [7:0] lat_d_b;
   logic       lat_en_b;
   logic       busy_b;
   logic       done_b;

`ifdef LATCH_STROBE_PARITY_EN
   logic       lat_par;
   logic       lat_par_b;
`endif

   int checks_total  = 0;
   int checks_passed = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;

   exp_t rise_q[$];
   exp_t done_q[$];
   int   fall_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   latch_strobe_tx dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .lat_d    (lat_d),
      .lat_en   (lat_en),
`ifdef LATCH_STROBE_PARITY_EN
      .lat_par  (lat_par),
`endif
      .busy     (busy),
      .done     (done)
   );

   latch_strobe_tx #(.DATA_W(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(0)) dut_b (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid_b),
      .in_ready (in_ready_b),
      .in_data  (in_data_b),
      .lat_d    (lat_d_b),
      .lat_en   (lat_en_b),
`ifdef LATCH_STROBE_PARITY_EN
      .lat_par  (lat_par_b),
`endif
      .busy     (busy_b),
      .done     (done_b)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag_unexpected(input string name);
      checks_total++;
      $display("[TB] FAIL %s: event seen with no expectation queued (cycle %0d)", name, cyc);
   endtask

   // Accepted at edge k: enable rises k+1, falls k+3, done at k+4.
   task automatic expect_txn(input int k, input logic [7:0] d);
      rise_q.push_back('{cyc: k + 1, data: d});
      fall_q.push_back(k + 3);
      done_q.push_back('{cyc: k + 4, data: d});
   endtask

   // Called at a negedge with the default DUT idle; returns acceptance edge.
   task automatic apply_stimulus(input logic [7:0] d, output int k);
      k        = cyc + 1;
      in_valid = 1'b1;
      in_data  = d;
      expect_txn(k, d);
   endtask

   initial begin : monitor
      logic prev_en;
      exp_t e;
      int   f;
      prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_en = 1'b0;
            continue;
         end
         if (lat_en && !prev_en) begin
            if (rise_q.size() == 0) begin
               flag_unexpected("lat_en_rise");
            end else begin
               e = rise_q.pop_front();
               check_output("rise_cycle", cyc, e.cyc);
               check_output("rise_data", {24'd0, lat_d}, {24'd0, e.data});
            end
         end
         if (!lat_en && prev_en) begin
            if (fall_q.size() == 0) begin
               flag_unexpected("lat_en_fall");
            end else begin
               f = fall_q.pop_front();
               check_output("fall_cycle", cyc, f);
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               flag_unexpected("done");
            end else begin
               e = done_q.pop_front();
               check_output("done_cycle", cyc, e.cyc);
               check_output("done_data", {24'd0, lat_d}, {24'd0, e.data});
               check_output("done_ready", {31'd0, in_ready}, 32'd1);
               check_output("done_en_low", {31'd0, lat_en}, 32'd0);
            end
         end
         prev_en = lat_en;
      end
   end

   initial begin : driver
      int k;
      rstn       = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      in_valid_b = 1'b0;
      in_data_b  = 8'h00;
      #12;
      check_output("rst_lat_d", {24'd0, lat_d}, 32'h0);
      check_output("rst_lat_en", {31'd0, lat_en}, 32'd0);
      check_output("rst_done", {31'd0, done}, 32'd0);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);

      // Single word with default timing
      apply_stimulus(8'hA5, k);
      @(negedge clk);
      in_valid = 1'b0;
      check_output("a5_lat_d", {24'd0, lat_d}, 32'hA5);
      check_output("a5_busy", {31'd0, busy}, 32'd1);
      check_output("a5_ready", {31'd0, in_ready}, 32'd0);
      repeat (5) @(negedge clk);

      // in_valid held high: second word accepted 5 cycles after the first
      apply_stimulus(8'h11, k);
      expect_txn(k + 5, 8'h22);
      @(negedge clk);
      in_data = 8'h22;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      check_output("b2b_lat_d", {24'd0, lat_d}, 32'h22);
      repeat (5) @(negedge clk);

      // New word offered while busy must be ignored
      apply_stimulus(8'h3C, k);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      check_output("busy_lat_d", {24'd0, lat_d}, 32'h3C);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in the middle of STROBE aborts without a done pulse
      apply_stimulus(8'h77, k);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_output("pre_rst_en", {31'd0, lat_en}, 32'd1);
      #2 rstn = 1'b0;
      fall_q.delete();
      done_q.delete();
      #1;
      check_output("mid_rst_en", {31'd0, lat_en}, 32'd0);
      check_output("mid_rst_lat_d", {24'd0, lat_d}, 32'h0);
      check_output("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      @(negedge clk);
      #2 rstn = 1'b1;
      k = cyc + 1;
      expect_txn(k, 8'h5A);
      @(negedge clk);
      in_valid = 1'b0;
      check_output("post_rst_lat_d", {24'd0, lat_d}, 32'h5A);
      repeat (5) @(negedge clk);

`ifdef LATCH_STROBE_PARITY_EN
      apply_stimulus(8'h07, k);
      @(negedge clk);
      in_valid = 1'b0;
      check_output("par_07", {31'd0, lat_par}, 32'd1);
      repeat (5) @(negedge clk);
      apply_stimulus(8'h03, k);
      @(negedge clk);
      in_valid = 1'b0;
      check_output("par_03", {31'd0, lat_par}, 32'd0);
      repeat (5) @(negedge clk);
`endif

      // No-hold, single-cycle pulse configuration
      in_valid_b = 1'b1;
      in_data_b  = 8'h96;
      @(negedge clk);
      in_valid_b = 1'b0;
      check_output("nh_lat_d", {24'd0, lat_d_b}, 32'h96);
      check_output("nh_busy", {31'd0, busy_b}, 32'd1);
      check_output("nh_en_setup", {31'd0, lat_en_b}, 32'd0);
      @(negedge clk);
      check_output("nh_en_strobe", {31'd0, lat_en_b}, 32'd1);
      check_output("nh_done_early", {31'd0, done_b}, 32'd0);
      @(negedge clk);
      check_output("nh_en_fall", {31'd0, lat_en_b}, 32'd0);
      check_output("nh_done", {31'd0, done_b}, 32'd1);
      check_output("nh_ready", {31'd0, in_ready_b}, 32'd1);
      @(negedge clk);
      check_output("nh_done_once", {31'd0, done_b}, 32'd0);
      check_output("nh_lat_d_kept", {24'd0, lat_d_b}, 32'h96);
      in_valid_b = 1'b1;
      in_data_b  = 8'h3D;
      @(negedge clk);
      in_valid_b = 1'b0;
      check_output("nh_lat_d_next", {24'd0, lat_d_b}, 32'h3D);
      repeat (4) @(negedge clk);

      check_output("sb_empty", rise_q.size() + fall_q.size() + done_q.size(), 32'd0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/latch_strobe_tx.md
LATCH_STROBE_TX -- requirements
Module: latch_strobe_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the data word and latch data bus.
REQ-002 SHALL have parameter SETUP_CYC, default 1, range 1..15, cycles lat_d is stable before lat_en rises.
REQ-003 SHALL have parameter PULSE_CYC, default 2, range 1..15, cycles lat_en is high.
REQ-004 SHALL have parameter HOLD_CYC, default 1, range 0..15, cycles lat_d is held after lat_en falls.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, upstream word valid.
REQ-009 SHALL have port in_ready, output, 1, block can accept a word.
REQ-010 SHALL have port in_data, input, DATA_W, upstream word.
REQ-011 SHALL have port lat_d, output, DATA_W, data driven to the downstream transparent latch.
REQ-012 SHALL have port lat_en, output, 1, level enable driven to the downstream latch.
REQ-013 SHALL have port busy, output, 1, transaction in progress.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a transaction completes.

Function
REQ-015 SHALL implement the FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE, skipping HOLD when HOLD_CYC=0.
REQ-016 SHALL decode in_ready = (state==IDLE) and busy = (state!=IDLE) from state only, with no combinational path from in_valid.
REQ-017 SHALL accept a word on a rising edge with in_valid && in_ready, register in_data into lat_d on that edge, and enter SETUP.
REQ-018 SHALL, for acceptance at edge k, raise lat_en at edge k+SETUP_CYC and lower it at edge k+SETUP_CYC+PULSE_CYC, with lat_en glitch-free because it is driven from a flop.
REQ-019 SHALL hold lat_d constant from edge k through edge k+SETUP_CYC+PULSE_CYC+HOLD_CYC.
REQ-020 SHALL return to IDLE and pulse done high for exactly one cycle at edge k+SETUP_CYC+PULSE_CYC+HOLD_CYC.
REQ-021 SHALL make the next acceptance possible no earlier than the edge after done, giving a minimum period of SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
REQ-022 SHALL ignore in_valid and in_data while busy, leaving lat_d and the phase timing unchanged.
REQ-023 SHALL retain the last lat_d value in IDLE with lat_en low.
REQ-024 SHALL use a 4-bit phase down-counter that is loaded on each state entry, with state advancing when the counter reaches 0; the counter SHALL NOT wrap.

Reset
REQ-025 SHALL, when rstn is low, immediately force state=IDLE, lat_d=0, lat_en=0, done=0, counter=0, busy=0 and in_ready=1.
REQ-026 SHALL abort any transaction interrupted by reset, including one in STROBE, with no done pulse; lat_en SHALL fall asynchronously.
REQ-027 SHALL resume normal acceptance on the first rising edge after rstn deasserts.

Configuration
REQ-028 SHALL, when macro LATCH_STROBE_PARITY_EN is defined, add output lat_par, 1 bit, carrying the even parity (XOR) of the accepted word; lat_par SHALL be registered with lat_d, held with it, and reset to 0.
REQ-029 SHALL, when LATCH_STROBE_PARITY_EN is undefined, have no lat_par port, with all other behaviour identical.

Structure
REQ-030 SHALL take from package latch_strobe_pkg:
- the state enum typedef (IDLE, SETUP, STROBE, HOLD);
- the parameter default constants;
- the counter width constant (4).
REQ-031 SHALL place the loadable down-counter in sub-module lst_phase_counter (load, load_val, zero flag, async active-low reset).

Verification
REQ-032 SHALL cover: default parameters, send 0xA5 at edge k -> lat_d=0xA5 from k, lat_en high for edges k+1..k+3 (2 cycles), done at k+4, in_ready again at k+4.
REQ-033 SHALL cover: in_valid held high with 0x11 then 0x22 -> second acceptance exactly 5 cycles after the first, and two lat_en pulses separated by 3 low cycles.
REQ-034 SHALL cover: in_valid=1 with in_data=0xFF during STROBE of 0x3C -> lat_d stays 0x3C, and only one done pulse.
REQ-035 SHALL cover: rstn low mid-STROBE -> lat_en=0 and lat_d=0 without waiting for a clock edge, no done pulse, in_ready=1, and 0x5A accepted on the first edge after release.
REQ-036 SHALL cover: HOLD_CYC=0, PULSE_CYC=1 -> done on the same edge lat_en falls, and lat_d changes at the next acceptance only.
REQ-037 SHALL cover: LATCH_STROBE_PARITY_EN defined, send 0x07 -> lat_par=1; send 0x03 -> lat_par=0.
